// File: rtl/labft_error_responder.sv
// -----------------------------------------------------------------------------
// labft_error_responder
//
// Reaction side of the LABFT checksum path. After every accumulated tile it
// waits for the detector's error flags to settle, classifies the tile as clean
// or corrupted, and answers the detector with an `interrupt`. Corrupted tiles
// are re-run through bounded `recompute` requests to the array sequencer. Once
// the retry budget for a tile is spent, a sticky `fault` is raised and held
// until the host acknowledges it.
//
// Optional feature macro: LABFT_ERR_LOG_EN
//   defined     -> `err_count` is a saturating count of corrupted-tile events
//   not defined -> no counter register; `err_count` is tied to 0
//
// Parameters
//   checkLatency  cycles from tile_done to a valid error sample (1..15)
//   maxRetries    recompute attempts allowed per tile (1..15)
//   retryWidth    width of retry_count
//   errCountWidth width of err_count
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   tile_done    single-cycle pulse, accumulator finished a tile
//   error        {w,x,y,z} checksum mismatch flags from the detector
//   host_ack     host acknowledges a fault (only acted on in FAULT)
//   interrupt    clears the detector; held high while in FAULT
//   recompute    single-cycle pulse, re-run the current tile
//   tile_ok      single-cycle pulse, tile passed its checksum check
//   fault        sticky flag, retries exhausted
//   syndrome     OR of error samples since last clean tile / host_ack
//   retry_count  recompute attempts issued for the current tile
//   overrun      single-cycle pulse, tile_done arrived outside IDLE
//   err_count    saturating count of corrupted-tile events
// -----------------------------------------------------------------------------
module labft_error_responder #(
    parameter int checkLatency  = 2,
    parameter int maxRetries    = 3,
    parameter int retryWidth    = $clog2(maxRetries + 1),
    parameter int errCountWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tile_done,
    input  logic [3:0]               error,
    input  logic                     host_ack,
    output logic                     interrupt,
    output logic                     recompute,
    output logic                     tile_ok,
    output logic                     fault,
    output logic [3:0]               syndrome,
    output logic [retryWidth-1:0]    retry_count,
    output logic                     overrun,
    output logic [errCountWidth-1:0] err_count
);

    // checkLatency is at most 15, so a 4-bit down-counter always suffices.
    localparam int CntWidth = 4;
    localparam logic [CntWidth-1:0]   CntLoad  = CntWidth'(checkLatency - 1);
    localparam logic [retryWidth-1:0] RetryMax = retryWidth'(maxRetries);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_FAULT
    } state_e;

    state_e                  state_q;
    logic [CntWidth-1:0]     cnt_q;
    logic [retryWidth-1:0]   retry_q;
    logic [3:0]              syndrome_q;
    logic                    interrupt_q;
    logic                    recompute_q;
    logic                    tile_ok_q;
    logic                    fault_q;
    logic                    overrun_q;

    // The error sample is taken on the edge that ends the last WAIT cycle.
    logic                    sample_now;
    logic                    sample_bad;
    logic [3:0]              syndrome_d;
    logic [retryWidth-1:0]   retry_d;

    assign sample_now = (state_q == S_WAIT) && (cnt_q == '0);
    assign sample_bad = (error != 4'b0000);
    assign syndrome_d = syndrome_q | error;
    assign retry_d    = retry_q + 1'b1;

    // Single FSM block; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: reset is sampled on the clock edge only; a tile in flight is
            // simply dropped, no interrupt is emitted for it.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            syndrome_q  <= '0;
            interrupt_q <= 1'b0;
            recompute_q <= 1'b0;
            tile_ok_q   <= 1'b0;
            fault_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below are
            // overridden by later assignments in the same block, which is how the
            // single-cycle pulses fall back to 0 without extra logic.
            interrupt_q <= 1'b0;
            recompute_q <= 1'b0;
            tile_ok_q   <= 1'b0;
            overrun_q   <= tile_done && (state_q != S_IDLE);

            case (state_q)
                S_IDLE: begin
                    if (tile_done) begin
                        cnt_q   <= CntLoad;
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (sample_now) begin
                        interrupt_q <= 1'b1;
                        state_q     <= S_RESP;
                        if (!sample_bad) begin
                            tile_ok_q  <= 1'b1;
                            retry_q    <= '0;
                            syndrome_q <= '0;
                        end else if (retry_q < RetryMax) begin
                            recompute_q <= 1'b1;
                            retry_q     <= retry_d;
                            syndrome_q  <= syndrome_d;
                        end else begin
                            // Budget spent: the retry count stays at its max.
                            syndrome_q <= syndrome_d;
                            fault_q    <= 1'b1;
                            state_q    <= S_FAULT;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                // One cycle in which the response pulses are visible.
                S_RESP: begin
                    state_q <= S_IDLE;
                end

                S_FAULT: begin
                    if (host_ack) begin
                        fault_q    <= 1'b0;
                        retry_q    <= '0;
                        syndrome_q <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        interrupt_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign interrupt   = interrupt_q;
    assign recompute   = recompute_q;
    assign tile_ok     = tile_ok_q;
    assign fault       = fault_q;
    assign syndrome    = syndrome_q;
    assign retry_count = retry_q;
    assign overrun     = overrun_q;

`ifdef LABFT_ERR_LOG_EN
    // Every corrupted sample counts, whether it leads to a retry or a fault.
    logic                     err_event;
    logic [errCountWidth-1:0] err_count_q;

    assign err_event = sample_now && sample_bad;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count_q <= '0;
        end else if (err_event && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_labft_error_responder.sv
// -----------------------------------------------------------------------------
// tb_labft_error_responder
//
// Directed bench for labft_error_responder with checkLatency=2, maxRetries=2
// and a 2-bit error counter so that saturation is reached quickly. Expected
// err_count follows LABFT_ERR_LOG_EN: a saturating event count when defined,
// constant 0 otherwise.
// -----------------------------------------------------------------------------
module tb_labft_error_responder;

    localparam int Lat  = 2;
    localparam int MaxR = 2;
    localparam int RW   = $clog2(MaxR + 1);
    localparam int ECW  = 2;

`ifdef LABFT_ERR_LOG_EN
    localparam bit LogEn = 1'b1;
`else
    localparam bit LogEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           tile_done;
    logic [3:0]     error;
    logic           host_ack;
    logic           interrupt;
    logic           recompute;
    logic           tile_ok;
    logic           fault;
    logic [3:0]     syndrome;
    logic [RW-1:0]  retry_count;
    logic           overrun;
    logic [ECW-1:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int events  = 0;

    labft_error_responder #(
        .checkLatency (Lat),
        .maxRetries   (MaxR),
        .errCountWidth(ECW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tile_done  (tile_done),
        .error      (error),
        .host_ack   (host_ack),
        .interrupt  (interrupt),
        .recompute  (recompute),
        .tile_ok    (tile_ok),
        .fault      (fault),
        .syndrome   (syndrome),
        .retry_count(retry_count),
        .overrun    (overrun),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Expected counter value after n corrupted-tile events.
    function automatic logic [31:0] exp_ec(input int n);
        if (!LogEn) return 32'd0;
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag,
                               input logic intr, input logic rec, input logic ok,
                               input logic flt, input logic [3:0] syn,
                               input logic [RW-1:0] rc, input logic ovr,
                               input logic [31:0] ec);
        check({tag, ".interrupt"},   32'(interrupt),   32'(intr));
        check({tag, ".recompute"},   32'(recompute),   32'(rec));
        check({tag, ".tile_ok"},     32'(tile_ok),     32'(ok));
        check({tag, ".fault"},       32'(fault),       32'(flt));
        check({tag, ".syndrome"},    32'(syndrome),    32'(syn));
        check({tag, ".retry_count"}, 32'(retry_count), 32'(rc));
        check({tag, ".overrun"},     32'(overrun),     32'(ovr));
        check({tag, ".err_count"},   32'(err_count),   ec);
    endtask

    // Advance one cycle; observe just after the edge, away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue a tile in the current cycle T with the given error flags, and
    // return positioned at T+3 where the response is visible.
    task automatic tile(input logic [3:0] err);
        tile_done = 1'b1;
        error     = err;
        cyc();
        tile_done = 1'b0;
        cyc();
        cyc();
        error = 4'b0000;
    endtask

    initial begin
        rst       = 1'b0;
        tile_done = 1'b0;
        error     = 4'b0000;
        host_ack  = 1'b0;
        cyc();
        cyc();
        expect_outs("reset", 0, 0, 0, 0, 4'h0, 0, 0, exp_ec(0));
        rst = 1'b1;
        cyc();

        // Clean tile: response only at T+3.
        tile_done = 1'b1;
        cyc();
        tile_done = 1'b0;
        check("clean.early_int", 32'(interrupt), 32'd0);
        cyc();
        check("clean.t2_int", 32'(interrupt), 32'd0);
        cyc();
        expect_outs("clean.resp", 1, 0, 1, 0, 4'h0, 0, 0, exp_ec(0));
        cyc();
        expect_outs("clean.after", 0, 0, 0, 0, 4'h0, 0, 0, exp_ec(0));

        // host_ack outside FAULT is ignored.
        host_ack = 1'b1;
        cyc();
        host_ack = 1'b0;
        expect_outs("ack_idle", 0, 0, 0, 0, 4'h0, 0, 0, exp_ec(0));

        // Single retry then pass.
        tile(4'b0100);
        events++;
        expect_outs("retry1.resp", 1, 1, 0, 0, 4'b0100, 1, 0, exp_ec(events));
        cyc();
        expect_outs("retry1.after", 0, 0, 0, 0, 4'b0100, 1, 0, exp_ec(events));
        tile(4'b0000);
        expect_outs("retry1.pass", 1, 0, 1, 0, 4'h0, 0, 0, exp_ec(events));
        cyc();

        // Retry exhaustion.
        tile(4'b0001);
        events++;
        expect_outs("exh.r1", 1, 1, 0, 0, 4'b0001, 1, 0, exp_ec(events));
        cyc();
        tile(4'b0010);
        events++;
        expect_outs("exh.r2", 1, 1, 0, 0, 4'b0011, 2, 0, exp_ec(events));
        cyc();
        tile(4'b1000);
        events++;
        expect_outs("exh.fault", 1, 0, 0, 1, 4'b1011, 2, 0, exp_ec(events));
        cyc();
        expect_outs("exh.hold", 1, 0, 0, 1, 4'b1011, 2, 0, exp_ec(events));
        tile_done = 1'b1;          // tile_done while in FAULT
        cyc();
        tile_done = 1'b0;
        expect_outs("exh.ovr", 1, 0, 0, 1, 4'b1011, 2, 1, exp_ec(events));
        host_ack = 1'b1;
        cyc();
        host_ack = 1'b0;
        expect_outs("exh.ack", 0, 0, 0, 0, 4'h0, 0, 0, exp_ec(events));
        cyc();

        // Overrun: tile_done at T and T+1.
        tile_done = 1'b1;
        cyc();
        cyc();
        tile_done = 1'b0;
        expect_outs("ovr.pulse", 0, 0, 0, 0, 4'h0, 0, 1, exp_ec(events));
        cyc();
        expect_outs("ovr.resp", 1, 0, 1, 0, 4'h0, 0, 0, exp_ec(events));
        cyc();
        expect_outs("ovr.single", 0, 0, 0, 0, 4'h0, 0, 0, exp_ec(events));
        cyc();
        check("ovr.no_second", 32'(interrupt), 32'd0);

        // Reset mid-operation.
        tile_done = 1'b1;
        error     = 4'b0100;
        cyc();
        tile_done = 1'b0;
        rst       = 1'b0;
        cyc();
        rst    = 1'b1;
        events = 0;
        expect_outs("rstmid.t2", 0, 0, 0, 0, 4'h0, 0, 0, exp_ec(0));
        cyc();
        expect_outs("rstmid.t3", 0, 0, 0, 0, 4'h0, 0, 0, exp_ec(0));
        error = 4'b0000;
        cyc();
        check("rstmid.t4_int", 32'(interrupt), 32'd0);
        tile(4'b0000);
        expect_outs("rstmid.clean", 1, 0, 1, 0, 4'h0, 0, 0, exp_ec(0));
        cyc();

        // Saturation: five corrupted-tile events (third one faults).
        for (int i = 0; i < 5; i++) begin
            tile(4'b0001);
            events++;
            check($sformatf("sat.ec%0d", i), 32'(err_count), exp_ec(events));
            cyc();
            if (fault) begin
                host_ack = 1'b1;
                cyc();
                host_ack = 1'b0;
            end
        end
        check("sat.final", 32'(err_count), LogEn ? 32'd3 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
